// File: rtl/alu_arbiter_if.sv
// Requester/response handshake bundle between the two ALU clients and the arbiter.
interface alu_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 4
);
  logic              req0_valid;
  logic              req0_ready;
  logic [OP_W-1:0]   req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              req1_valid;
  logic              req1_ready;
  logic [OP_W-1:0]   req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic              rsp_ovf;
  logic              rsp_err;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_result, rsp_zero, rsp_ovf, rsp_err
  );

  // Requester side
  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_result, rsp_zero, rsp_ovf, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of one registered ALU between two requesters, one op in flight.
module alu_arbiter #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned MAX_OP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  alu_arbiter_if.slave      bus,
  output logic [OP_W-1:0]   alu_control,
  output logic [DATA_W-1:0] alu_oper1,
  output logic [DATA_W-1:0] alu_oper2,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_overflow
);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  state_e            state_q, state_d;
  logic              prio_q, prio_d;
  logic              grant_q, grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OP_W-1:0]   alu_control_q, alu_control_d;
  logic [DATA_W-1:0] alu_oper1_q, alu_oper1_d;
  logic [DATA_W-1:0] alu_oper2_q, alu_oper2_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              rsp_ovf_q, rsp_ovf_d;
  logic              rsp_err_q, rsp_err_d;

  logic              win0_c, win1_c, accept_c, op_err_c, rsp_hs_c;
  logic [OP_W-1:0]   op_c;
  logic [DATA_W-1:0] a_c, b_c;

  // Arbitration: lone requester wins, ties go to prio; select the winner's payload
  always_comb begin
    win0_c   = bus.req0_valid & (~bus.req1_valid | ~prio_q);
    win1_c   = bus.req1_valid & (~bus.req0_valid | prio_q);
    accept_c = (state_q == IDLE) & (win0_c | win1_c);
    op_c     = win1_c ? bus.req1_op : bus.req0_op;
    a_c      = win1_c ? bus.req1_a  : bus.req0_a;
    b_c      = win1_c ? bus.req1_b  : bus.req0_b;
    op_err_c = op_c > OP_W'(MAX_OP);
    rsp_hs_c = (state_q == DONE) & rsp_valid_q[grant_q] & bus.rsp_ready[grant_q];
  end

  assign bus.req0_ready = (state_q == IDLE) & win0_c;
  assign bus.req1_ready = (state_q == IDLE) & win1_c;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_ovf    = rsp_ovf_q;
  assign bus.rsp_err    = rsp_err_q;
  assign alu_control    = alu_control_q;
  assign alu_oper1      = alu_oper1_q;
  assign alu_oper2      = alu_oper2_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: illegal opcodes skip the ALU and answer straight away
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = op_err_c ? DONE : BUSY;
      BUSY:    if (cnt_q == '0) state_d = DONE;
      DONE:    if (rsp_hs_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and response updates per state
  always_comb begin
    prio_d        = prio_q;
    grant_d       = grant_q;
    cnt_d         = cnt_q;
    alu_control_d = alu_control_q;
    alu_oper1_d   = alu_oper1_q;
    alu_oper2_d   = alu_oper2_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_zero_d    = rsp_zero_q;
    rsp_ovf_d     = rsp_ovf_q;
    rsp_err_d     = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          grant_d = win1_c;
          if (op_err_c) begin
            rsp_valid_d  = win1_c ? 2'b10 : 2'b01;
            rsp_result_d = '0;
            rsp_zero_d   = 1'b0;
            rsp_ovf_d    = 1'b0;
            rsp_err_d    = 1'b1;
          end else begin
            alu_control_d = op_c;
            alu_oper1_d   = a_c;
            alu_oper2_d   = b_c;
            cnt_d         = CNT_W'(ALU_LAT);
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          rsp_valid_d  = grant_q ? 2'b10 : 2'b01;
          rsp_result_d = alu_result;
          rsp_zero_d   = ~|alu_result;
          rsp_ovf_d    = alu_overflow;
          rsp_err_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (rsp_hs_c) begin
          rsp_valid_d = 2'b00;
          prio_d      = ~grant_q;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q        <= 1'b0;
      grant_q       <= 1'b0;
      cnt_q         <= '0;
      alu_control_q <= '0;
      alu_oper1_q   <= '0;
      alu_oper2_q   <= '0;
      rsp_valid_q   <= 2'b00;
      rsp_result_q  <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_ovf_q     <= 1'b0;
      rsp_err_q     <= 1'b0;
    end else begin
      prio_q        <= prio_d;
      grant_q       <= grant_d;
      cnt_q         <= cnt_d;
      alu_control_q <= alu_control_d;
      alu_oper1_q   <= alu_oper1_d;
      alu_oper2_q   <= alu_oper2_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_ovf_q     <= rsp_ovf_d;
      rsp_err_q     <= rsp_err_d;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (ALU latency 1 and 3), each with a behavioural ALU.
module tb_alu_arbiter;
  logic clk;
  logic rst;
  logic sel;
  int   tests;
  int   fails;
  int   prio_m [2];

  logic [1:0]  r_valid;
  logic [3:0]  r_op [2];
  logic [31:0] r_a [2];
  logic [31:0] r_b [2];
  logic [1:0]  r_rsp_ready;

  logic [3:0]  c1, c3;
  logic [31:0] x1, y1, x3, y3, res1;
  logic        ovf1;
  logic [32:0] s1, s2, s3;

  logic        o_ready0, o_ready1, o_zero, o_ovf, o_err;
  logic [1:0]  o_rsp_valid;
  logic [31:0] o_res, o_op1, o_op2;
  logic [3:0]  o_ctl;

  alu_arbiter_if #(.DATA_W(32), .OP_W(4)) b1 ();
  alu_arbiter_if #(.DATA_W(32), .OP_W(4)) b3 ();

  alu_arbiter #(.DATA_W(32), .OP_W(4), .ALU_LAT(1), .MAX_OP(4)) dut1 (
    .clk(clk), .rst(rst), .bus(b1),
    .alu_control(c1), .alu_oper1(x1), .alu_oper2(y1),
    .alu_result(res1), .alu_overflow(ovf1)
  );

  alu_arbiter #(.DATA_W(32), .OP_W(4), .ALU_LAT(3), .MAX_OP(4)) dut3 (
    .clk(clk), .rst(rst), .bus(b3),
    .alu_control(c3), .alu_oper1(x3), .alu_oper2(y3),
    .alu_result(s3[31:0]), .alu_overflow(s3[32])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: {overflow, result}
  function automatic logic [32:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] m;
    logic [31:0] r;
    logic        v;
    m = 64'(a) * 64'(b);
    r = 32'd0;
    v = 1'b0;
    case (op)
      4'd0: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd1: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd2: begin r = m[31:0]; v = |m[63:32]; end
      4'd3: r = a & b;
      4'd4: r = a | b;
      default: r = 32'd0;
    endcase
    return {v, r};
  endfunction

  // Registered ALUs of latency 1 and 3
  always @(posedge clk) begin
    {ovf1, res1} <= alu_f(c1, x1, y1);
    s1 <= alu_f(c3, x3, y3);
    s2 <= s1;
    s3 <= s2;
  end

  assign b1.req0_valid = !sel && r_valid[0];
  assign b1.req1_valid = !sel && r_valid[1];
  assign b3.req0_valid = sel && r_valid[0];
  assign b3.req1_valid = sel && r_valid[1];
  assign b1.req0_op = r_op[0];
  assign b1.req0_a  = r_a[0];
  assign b1.req0_b  = r_b[0];
  assign b1.req1_op = r_op[1];
  assign b1.req1_a  = r_a[1];
  assign b1.req1_b  = r_b[1];
  assign b3.req0_op = r_op[0];
  assign b3.req0_a  = r_a[0];
  assign b3.req0_b  = r_b[0];
  assign b3.req1_op = r_op[1];
  assign b3.req1_a  = r_a[1];
  assign b3.req1_b  = r_b[1];
  assign b1.rsp_ready = sel ? 2'b00 : r_rsp_ready;
  assign b3.rsp_ready = sel ? r_rsp_ready : 2'b00;

  always_comb begin
    o_ready0    = sel ? b3.req0_ready : b1.req0_ready;
    o_ready1    = sel ? b3.req1_ready : b1.req1_ready;
    o_rsp_valid = sel ? b3.rsp_valid  : b1.rsp_valid;
    o_res       = sel ? b3.rsp_result : b1.rsp_result;
    o_zero      = sel ? b3.rsp_zero   : b1.rsp_zero;
    o_ovf       = sel ? b3.rsp_ovf    : b1.rsp_ovf;
    o_err       = sel ? b3.rsp_err    : b1.rsp_err;
    o_ctl       = sel ? c3 : c1;
    o_op1       = sel ? x3 : x1;
    o_op2       = sel ? y3 : y1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    r_op[i]    = op;
    r_a[i]     = a;
    r_b[i]     = b;
    r_valid[i] = 1'b1;
  endtask

  function automatic logic [31:0] rnd_data();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 3));
      1:       return ($urandom_range(0, 1) == 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic add_random();
    logic [1:0] m;
    m = 2'($urandom_range(0, 3)) & ~r_valid;
    if (r_valid == 2'b00 && m == 2'b00) m = 2'($urandom_range(1, 2));
    for (int i = 0; i < 2; i++)
      if (m[i])
        set_req(i, ($urandom_range(0, 9) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4)),
                rnd_data(), rnd_data());
  endtask

  // One full transaction: arbitration, latency, held response, handshake.
  // Called with requests already driven, one ns after a rising edge.
  task automatic serve(input int hold, input logic oth);
    int          w, lat_m, s;
    logic [32:0] e;
    logic        ee, ez;
    logic [3:0]  pc;
    logic [31:0] p1, p2;
    logic [1:0]  oh;
    s = sel ? 1 : 0;
    #1;
    if (r_valid == 2'b11) w = prio_m[s];
    else                  w = r_valid[1] ? 1 : 0;
    check("req0_ready", 64'(o_ready0), 64'(w == 0));
    check("req1_ready", 64'(o_ready1), 64'(w == 1));
    pc = o_ctl;
    p1 = o_op1;
    p2 = o_op2;
    ee = r_op[w] > 4'd4;
    e  = ee ? 33'd0 : alu_f(r_op[w], r_a[w], r_b[w]);
    ez = !ee && (e[31:0] == 32'd0);
    lat_m = ee ? 0 : ((sel ? 3 : 1) + 1);
    oh = (w == 1) ? 2'b10 : 2'b01;
    r_rsp_ready        = 2'b00;
    r_rsp_ready[w]     = (hold == 0);
    r_rsp_ready[1 - w] = oth;
    @(posedge clk); #1;
    r_valid[w] = 1'b0;
    check("alu_control", 64'(o_ctl), 64'(ee ? pc : r_op[w]));
    check("alu_oper1", 64'(o_op1), 64'(ee ? p1 : r_a[w]));
    check("alu_oper2", 64'(o_op2), 64'(ee ? p2 : r_b[w]));
    for (int k = 0; k < lat_m; k++) begin
      check("rsp_valid_wait", 64'(o_rsp_valid), 64'(2'b00));
      check("ready_busy", 64'({o_ready1, o_ready0}), 64'(2'b00));
      @(posedge clk); #1;
    end
    check("rsp_valid", 64'(o_rsp_valid), 64'(oh));
    check("rsp_result", 64'(o_res), 64'(e[31:0]));
    check("rsp_zero", 64'(o_zero), 64'(ez));
    check("rsp_ovf", 64'(o_ovf), 64'(e[32]));
    check("rsp_err", 64'(o_err), 64'(ee));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("rsp_valid_hold", 64'(o_rsp_valid), 64'(oh));
      check("rsp_result_hold", 64'(o_res), 64'(e[31:0]));
      check("ready_done", 64'({o_ready1, o_ready0}), 64'(2'b00));
    end
    r_rsp_ready[w] = 1'b1;
    @(posedge clk); #1;
    check("rsp_valid_clear", 64'(o_rsp_valid), 64'(2'b00));
    prio_m[s]   = 1 - w;
    r_rsp_ready = 2'b00;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    prio_m[0] = 0;
    prio_m[1] = 0;
    sel = 1'b0;
    rst = 1'b1;
    r_valid = 2'b00;
    r_rsp_ready = 2'b00;
    for (int i = 0; i < 2; i++) begin
      r_op[i] = 4'd0;
      r_a[i]  = 32'd0;
      r_b[i]  = 32'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("reset_rsp_valid", 64'(o_rsp_valid), 64'(2'b00));
    check("reset_alu_control", 64'(o_ctl), 64'(4'd0));
    check("reset_alu_oper1", 64'(o_op1), 64'(32'd0));
    check("reset_alu_oper2", 64'(o_op2), 64'(32'd0));
    check("reset_rsp_result", 64'(o_res), 64'(32'd0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Tie from reset: req0 first, then req1, then next tie back to req0
    set_req(0, 4'd1, 32'd9, 32'd9);
    set_req(1, 4'd1, 32'd9, 32'd9);
    serve(0, 1'b0);
    serve(0, 1'b0);
    set_req(0, 4'd0, 32'd1, 32'd2);
    set_req(1, 4'd0, 32'd3, 32'd4);
    serve(0, 1'b0);
    serve(0, 1'b0);

    // Single ADD with both response readies high
    set_req(0, 4'd0, 32'd5, 32'd7);
    serve(0, 1'b1);

    // MUL with held response while req0 stalls
    set_req(1, 4'd2, 32'h0001_0000, 32'h0001_0000);
    set_req(0, 4'd3, 32'hFFFF_0000, 32'h00FF_FF00);
    serve(5, 1'b1);
    serve(0, 1'b0);

    // Illegal opcode: no ALU issue, immediate error response
    set_req(0, 4'd9, 32'd123, 32'd456);
    serve(2, 1'b0);

    // Reset while BUSY: aborted, prio back to req0
    set_req(0, 4'd4, 32'd3, 32'd4);
    #1;
    check("rstbusy_ready0", 64'(o_ready0), 64'(1'b1));
    @(posedge clk); #1;
    r_valid = 2'b00;
    rst = 1'b1;
    #1;
    check("rstbusy_rsp_valid", 64'(o_rsp_valid), 64'(2'b00));
    check("rstbusy_alu_control", 64'(o_ctl), 64'(4'd0));
    check("rstbusy_alu_oper1", 64'(o_op1), 64'(32'd0));
    check("rstbusy_alu_oper2", 64'(o_op2), 64'(32'd0));
    @(posedge clk); #1;
    rst = 1'b0;
    prio_m[0] = 0;
    prio_m[1] = 0;
    repeat (3) begin
      @(posedge clk); #1;
      check("rstbusy_no_rsp", 64'(o_rsp_valid), 64'(2'b00));
    end
    set_req(0, 4'd4, 32'd3, 32'd4);
    set_req(1, 4'd1, 32'd10, 32'd3);
    serve(0, 1'b0);
    serve(1, 1'b1);

    // Randomized traffic on the latency-1 instance
    for (int n = 0; n < 40; n++) begin
      add_random();
      serve($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    for (int d = 0; d < 2; d++)
      if (r_valid != 2'b00) serve(0, 1'b0);

    // Latency-3 instance: AND then randomized traffic
    sel = 1'b1;
    set_req(1, 4'd3, 32'h0000_00F0, 32'h0000_003C);
    serve(0, 1'b0);
    for (int n = 0; n < 20; n++) begin
      add_random();
      serve($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    for (int d = 0; d < 2; d++)
      if (r_valid != 2'b00) serve(0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
